// File: rtl/rca_lsq_pkg.sv
// rca_lsq_pkg: shared types and constants for the RCA load/store queue.
//   XLEN        - data/address width
//   LSQ_DEPTH   - default number of buffered requests
//   fn3 codes   - access size/sign encodings (B, H, W, BU, HU)
//   lsq_entry_t - one queued request {addr, data, fn3, load}
//   lsq_state_t - issue FSM states
//   helpers     - store lane replication, byte enables, load extraction
package rca_lsq_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned LSQ_DEPTH = 4;

  localparam logic [2:0] LS_B_fn3 = 3'b000;
  localparam logic [2:0] LS_H_fn3 = 3'b001;
  localparam logic [2:0] LS_W_fn3 = 3'b010;
  localparam logic [2:0] L_BU_fn3 = 3'b100;
  localparam logic [2:0] L_HU_fn3 = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
  } lsq_entry_t;

  typedef enum logic [1:0] {
    LSQ_IDLE,
    LSQ_ISSUE,
    LSQ_WAIT_LOAD
  } lsq_state_t;

  // Size is carried by fn3[1:0] for both loads and stores (00 B, 01 H, else W).
  function automatic logic [XLEN-1:0] store_wdata(input logic [XLEN-1:0] d,
                                                  input logic [1:0]      sz);
    logic [XLEN-1:0] r;
    case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] lane,
                                          input logic [1:0] sz);
    logic [3:0] r;
    case (sz)
      2'b00:   r = 4'b0001 << lane;
      2'b01:   r = lane[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] rdata,
                                                  input logic [1:0]      lane,
                                                  input logic [2:0]      fn3);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (fn3)
      LS_B_fn3: r = {{(XLEN-8){b[7]}}, b};
      LS_H_fn3: r = {{(XLEN-16){h[15]}}, h};
      L_BU_fn3: r = {{(XLEN-8){1'b0}}, b};
      L_HU_fn3: r = {{(XLEN-16){1'b0}}, h};
      default:  r = rdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rca_lsq_if.sv
// rca_lsq_if: simple data-memory port between the LSQ and the memory arbiter.
//   master (LSQ side):    drives mem_addr, mem_wdata, mem_be, mem_re, mem_we
//                         samples mem_ack, mem_rdata, mem_rvalid
//   slave  (memory side): the mirror image
// mem_re/mem_we are held until mem_ack; mem_rvalid follows ack by >=1 cycle.
interface rca_lsq_if;
  import rca_lsq_pkg::*;

  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_re;
  logic            mem_we;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rvalid;

  modport master (
    output mem_addr, mem_wdata, mem_be, mem_re, mem_we,
    input  mem_ack, mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_be, mem_re, mem_we,
    output mem_ack, mem_rdata, mem_rvalid
  );

endinterface

// File: rtl/rca_lsq_fifo.sv
// rca_lsq_fifo: in-order FIFO of lsq_entry_t for the load/store queue.
//   clk, rst : clock, synchronous active-high reset
//   push,din : enqueue (ignored when full)
//   pop,dout : dequeue (ignored when empty); dout shows the head combinationally
//   full, empty, count : occupancy status
module rca_lsq_fifo
  import rca_lsq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  lsq_entry_t               din,
  input  logic                     pop,
  output lsq_entry_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  lsq_entry_t    store_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = store_q[rd_ptr];

endmodule

// File: rtl/rca_lsq.sv
// rca_lsq: load/store queue terminating the RCA memory-OU request interface.
// Buffers up to LSQ_DEPTH requests in order and issues them one at a time to
// a simple memory port; load results are extracted/extended and returned.
//   clk, rst          : clock, synchronous active-high reset
//   addr, data, fn3   : request byte address, store data, size/sign code
//   load, store       : request kind (exactly one must be set)
//   new_request       : enqueue strobe
//   lsq_full          : queue holds LSQ_DEPTH entries
//   load_data         : formatted load result (held until the next load)
//   load_complete     : one-cycle pulse, load_data valid
//   mem               : memory port (rca_lsq_if.master)
module rca_lsq
  import rca_lsq_pkg::*;
#(
  parameter int unsigned LSQ_DEPTH = rca_lsq_pkg::LSQ_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  data,
  input  logic [2:0]       fn3,
  input  logic             load,
  input  logic             store,
  input  logic             new_request,
  output logic             lsq_full,
  output logic [XLEN-1:0]  load_data,
  output logic             load_complete,
  rca_lsq_if.master        mem
);

  lsq_entry_t                 enq_entry;
  lsq_entry_t                 head;
  logic                       push;
  logic                       pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(LSQ_DEPTH):0] occupancy;

  lsq_state_t                 state;
  logic                       iss_load;
  logic [1:0]                 iss_lane;
  logic [2:0]                 iss_fn3;

  assign enq_entry = '{addr: addr, data: data, fn3: fn3, load: load};
  assign push      = new_request && (load ^ store) && !fifo_full;
  // Pop only from IDLE, so at most one memory transaction is ever outstanding.
  assign pop       = (state == LSQ_IDLE) && !fifo_empty;
  assign lsq_full  = (occupancy == ($clog2(LSQ_DEPTH)+1)'(LSQ_DEPTH));

  rca_lsq_fifo #(
    .DEPTH (LSQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (enq_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LSQ_IDLE;
      iss_load      <= 1'b0;
      iss_lane      <= '0;
      iss_fn3       <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= '0;
      mem.mem_re    <= 1'b0;
      mem.mem_we    <= 1'b0;
      load_data     <= '0;
      load_complete <= 1'b0;
    end else begin
      load_complete <= 1'b0;
      case (state)
        LSQ_IDLE: begin
          if (!fifo_empty) begin
            mem.mem_addr  <= {head.addr[XLEN-1:2], 2'b00};
            mem.mem_wdata <= store_wdata(head.data, head.fn3[1:0]);
            mem.mem_be    <= head.load ? 4'b0000
                                       : store_be(head.addr[1:0], head.fn3[1:0]);
            mem.mem_re    <= head.load;
            mem.mem_we    <= !head.load;
            iss_load      <= head.load;
            iss_lane      <= head.addr[1:0];
            iss_fn3       <= head.fn3;
            state         <= LSQ_ISSUE;
          end
        end
        LSQ_ISSUE: begin
          if (mem.mem_ack) begin
            mem.mem_re <= 1'b0;
            mem.mem_we <= 1'b0;
            state      <= iss_load ? LSQ_WAIT_LOAD : LSQ_IDLE;
          end
        end
        LSQ_WAIT_LOAD: begin
          if (mem.mem_rvalid) begin
            load_data     <= format_load(mem.mem_rdata, iss_lane, iss_fn3);
            load_complete <= 1'b1;
            state         <= LSQ_IDLE;
          end
        end
        default: state <= LSQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_lsq.sv
// tb_rca_lsq: directed self-checking bench for rca_lsq.
module tb_rca_lsq;
  import rca_lsq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] data;
  logic [2:0]  fn3;
  logic        load;
  logic        store;
  logic        new_request;
  logic        lsq_full;
  logic [31:0] load_data;
  logic        load_complete;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  rca_lsq_if mif ();

  rca_lsq #(
    .LSQ_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .data          (data),
    .fn3           (fn3),
    .load          (load),
    .store         (store),
    .new_request   (new_request),
    .lsq_full      (lsq_full),
    .load_data     (load_data),
    .load_complete (load_complete),
    .mem           (mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                     input logic ld, input logic st);
    addr = a; data = d; fn3 = f; load = ld; store = st; new_request = 1'b1;
    tick();
    new_request = 1'b0; load = 1'b0; store = 1'b0;
  endtask

  // Bounded wait for a memory strobe; n reports how many cycles it took.
  task automatic wait_strobe(input string tag, output int unsigned n);
    n = 0;
    while (!(mif.mem_re || mif.mem_we) && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_strobe"}, 32'(mif.mem_re || mif.mem_we), 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] d, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_be);
    int unsigned n;
    enq(a, d, f, 1'b0, 1'b1);
    wait_strobe(tag, n);
    check({tag, "_lat"},   n, 32'd1);
    check({tag, "_we"},    32'(mif.mem_we), 32'd1);
    check({tag, "_addr"},  mif.mem_addr, a & 32'hFFFF_FFFC);
    check({tag, "_wdata"}, mif.mem_wdata, exp_wdata);
    check({tag, "_be"},    32'(mif.mem_be), 32'(exp_be));
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    check({tag, "_we_off"}, 32'(mif.mem_we), 32'd0);
    check({tag, "_no_lc"},  32'(load_complete), 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] rd, input logic [31:0] exp);
    int unsigned n;
    enq(a, 32'h0, f, 1'b1, 1'b0);
    wait_strobe(tag, n);
    check({tag, "_lat"},  n, 32'd1);
    check({tag, "_re"},   32'(mif.mem_re), 32'd1);
    check({tag, "_addr"}, mif.mem_addr, a & 32'hFFFF_FFFC);
    check({tag, "_be"},   32'(mif.mem_be), 32'd0);
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    check({tag, "_re_off"}, 32'(mif.mem_re), 32'd0);
    mif.mem_rdata = rd; mif.mem_rvalid = 1'b1;
    tick();
    mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
    check({tag, "_lc"},   32'(load_complete), 32'd1);
    check({tag, "_data"}, load_data, exp);
    tick();
    check({tag, "_lc_off"},  32'(load_complete), 32'd0);
    check({tag, "_data_hold"}, load_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic        seen;

    rst = 1'b1; addr = '0; data = '0; fn3 = '0; load = 1'b0; store = 1'b0;
    new_request = 1'b0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0; mif.mem_rvalid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_re",    32'(mif.mem_re), 32'd0);
    check("rst_we",    32'(mif.mem_we), 32'd0);
    check("rst_be",    32'(mif.mem_be), 32'd0);
    check("rst_addr",  mif.mem_addr, 32'd0);
    check("rst_full",  32'(lsq_full), 32'd0);
    check("rst_lc",    32'(load_complete), 32'd0);
    check("rst_ldata", load_data, 32'd0);

    // SW with immediate ack: strobe from t+2
    enq(32'h100, 32'hDEAD_BEEF, LS_W_fn3, 1'b0, 1'b1);
    check("sw_t1_we", 32'(mif.mem_we), 32'd0);
    tick();
    check("sw_t2_we",    32'(mif.mem_we), 32'd1);
    check("sw_t2_re",    32'(mif.mem_re), 32'd0);
    check("sw_addr",     mif.mem_addr, 32'h100);
    check("sw_be",       32'(mif.mem_be), 32'hF);
    check("sw_wdata",    mif.mem_wdata, 32'hDEAD_BEEF);
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    check("sw_we_off", 32'(mif.mem_we), 32'd0);
    check("sw_no_lc",  32'(load_complete), 32'd0);
    tick();

    // SB then LB to the same byte, back to back
    enq(32'h103, 32'h0000_005A, LS_B_fn3, 1'b0, 1'b1);
    enq(32'h103, 32'h0, LS_B_fn3, 1'b1, 1'b0);
    check("sb_we",    32'(mif.mem_we), 32'd1);
    check("sb_addr",  mif.mem_addr, 32'h100);
    check("sb_wdata", mif.mem_wdata, 32'h5A5A_5A5A);
    check("sb_be",    32'(mif.mem_be), 32'h8);
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    check("sb_we_off", 32'(mif.mem_we), 32'd0);
    check("lb_t3_re",  32'(mif.mem_re), 32'd0);
    tick();
    check("lb_re",   32'(mif.mem_re), 32'd1);
    check("lb_addr", mif.mem_addr, 32'h100);
    check("lb_be",   32'(mif.mem_be), 32'h0);
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    mif.mem_rdata = 32'h80FF_FF11; mif.mem_rvalid = 1'b1;
    tick();
    mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
    check("lb_lc",   32'(load_complete), 32'd1);
    check("lb_data", load_data, 32'hFFFF_FF80);
    tick();
    check("lb_lc_off",    32'(load_complete), 32'd0);
    check("lb_data_hold", load_data, 32'hFFFF_FF80);

    // Load formatting
    do_load("lhu_202", 32'h202, L_HU_fn3, 32'h9ABC_1234, 32'h0000_9ABC);
    do_load("lh_202",  32'h202, LS_H_fn3, 32'h9ABC_1234, 32'hFFFF_9ABC);
    do_load("lbu_101", 32'h101, L_BU_fn3, 32'h1122_8344, 32'h0000_0083);
    do_load("lb_100",  32'h100, LS_B_fn3, 32'h0000_007F, 32'h0000_007F);
    do_load("lh_200",  32'h200, LS_H_fn3, 32'h0000_8001, 32'hFFFF_8001);
    do_load("lw_20c",  32'h20C, LS_W_fn3, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Store formatting
    do_store("sh_206", 32'h206, LS_H_fn3, 32'h1234_ABCD, 32'hABCD_ABCD, 4'b1100);
    do_store("sh_200", 32'h200, LS_H_fn3, 32'hFFFF_5555, 32'h5555_5555, 4'b0011);
    do_store("sb_101", 32'h101, LS_B_fn3, 32'h0000_0077, 32'h7777_7777, 4'b0010);
    tick();

    // Fill with ack held low: first store already popped, so five fit
    for (int i = 0; i < 5; i++) begin
      enq(32'h300 + 32'(4 * i), 32'h1000 + 32'(i), LS_W_fn3, 1'b0, 1'b1);
      if (i == 3) check("fill_not_full_3", 32'(lsq_full), 32'd0);
    end
    check("fill_full", 32'(lsq_full), 32'd1);
    enq(32'h400, 32'h0000_0BAD, LS_W_fn3, 1'b0, 1'b1);
    check("fill_full_hold", 32'(lsq_full), 32'd1);
    check("fill_head_addr", mif.mem_addr, 32'h300);
    for (int i = 0; i < 5; i++) begin
      wait_strobe("fill", n);
      check("fill_we",    32'(mif.mem_we), 32'd1);
      check("fill_addr",  mif.mem_addr, 32'h300 + 32'(4 * i));
      check("fill_wdata", mif.mem_wdata, 32'h1000 + 32'(i));
      mif.mem_ack = 1'b1;
      tick();
      mif.mem_ack = 1'b0;
      if (i == 0) begin
        check("fill_full_until_pop", 32'(lsq_full), 32'd1);
        tick();
        check("fill_full_released", 32'(lsq_full), 32'd0);
      end
    end
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | mif.mem_re | mif.mem_we;
    end
    check("fill_no_sixth", 32'(seen), 32'd0);

    // Invalid requests: load==store
    addr = 32'h600; data = 32'h1; fn3 = LS_W_fn3;
    load = 1'b1; store = 1'b1; new_request = 1'b1;
    tick();
    load = 1'b0; store = 1'b0;
    tick();
    new_request = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      seen = seen | mif.mem_re | mif.mem_we | load_complete;
      tick();
    end
    check("invalid_no_strobe", 32'(seen), 32'd0);
    check("invalid_not_full",  32'(lsq_full), 32'd0);

    // Reset while waiting for load data with two entries queued
    enq(32'h500, 32'h0, LS_W_fn3, 1'b1, 1'b0);
    enq(32'h504, 32'h1111_1111, LS_W_fn3, 1'b0, 1'b1);
    check("rwl_re", 32'(mif.mem_re), 32'd1);
    mif.mem_ack = 1'b1;
    enq(32'h508, 32'h2222_2222, LS_W_fn3, 1'b0, 1'b1);
    mif.mem_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rwl_re_off", 32'(mif.mem_re), 32'd0);
    check("rwl_we_off", 32'(mif.mem_we), 32'd0);
    check("rwl_full",   32'(lsq_full), 32'd0);
    check("rwl_ldata",  load_data, 32'd0);
    mif.mem_rdata = 32'h1234_5678; mif.mem_rvalid = 1'b1;
    tick();
    mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
    check("rwl_late_lc", 32'(load_complete), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      seen = seen | mif.mem_re | mif.mem_we | load_complete;
      tick();
    end
    check("rwl_queue_empty", 32'(seen), 32'd0);
    check("rwl_ldata_hold",  load_data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
